scaler_matrix_read: RTL and testbench

- Read side of the scaler line-buffer matrix: consumes lines already written into the RAM_NUM-deep ring of line RAMs and emits one column of a K-row pixel matrix per cycle to the scaler kernel.
- Tracks line availability from the writer's done/num handshake.
- Returns consumed lines to the writer through ram_read_done/ram_read_num so the writer's occupancy count stays coherent.

---
 rtl/scaler_matrix_read.sv | 225 ++++++++++++++++++++++
 tb/tb_scaler_matrix_read.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_matrix_read.sv
// Read side of the scaler line-buffer ring: streams K-row matrix columns from the
// line RAMs and hands consumed lines back to the writer.
module scaler_matrix_read #(
    parameter int KERNEL_MAX        = 4,
    parameter int KERNEL_BITWIDTH   = $clog2(KERNEL_MAX + 1),
    parameter int RAM_NUM           = KERNEL_MAX + 1,
    parameter int RAM_NUM_BITWIDTH  = $clog2(RAM_NUM + 1),
    parameter int RAM_DEEP          = 3840,
    parameter int RAM_ADDR_BITWIDTH = $clog2(RAM_DEEP),
    parameter int RAM_DATA_BITWIDTH = 8,
    parameter int RAM_RD_LATENCY    = 2,
    parameter int HEIGHT_BITWIDTH   = 12
) (
    input  logic                                    s_clk,
    input  logic                                    s_rst_n,
    input  logic                                    s_start,
    input  logic [KERNEL_BITWIDTH-1:0]              cfg_kernel_size,
    input  logic [RAM_ADDR_BITWIDTH-1:0]            cfg_img_width,
    input  logic [HEIGHT_BITWIDTH-1:0]              cfg_img_height,
    input  logic                                    ram_write_done,
    input  logic [RAM_NUM_BITWIDTH-1:0]             ram_write_num,
    output logic [RAM_NUM-1:0]                      ram_enb,
    output logic [RAM_ADDR_BITWIDTH-1:0]            ram_addrb,
    input  logic [RAM_NUM*RAM_DATA_BITWIDTH-1:0]    ram_doutb,
    output logic                                    ram_read_done,
    output logic [RAM_NUM_BITWIDTH-1:0]             ram_read_num,
    output logic                                    m_axis_matrix_valid,
    output logic [KERNEL_MAX*RAM_DATA_BITWIDTH-1:0] m_axis_matrix_data,
    output logic                                    m_axis_matrix_last,
    output logic                                    m_frame_done
);
    localparam int D  = RAM_DATA_BITWIDTH;
    localparam int NB = RAM_NUM_BITWIDTH;
    localparam int IW = $clog2(2 * RAM_NUM);
    localparam int AW = NB + 2;
    localparam int SW = $clog2(RAM_RD_LATENCY + 4);
    localparam logic [IW-1:0] RAM_NUM_I = IW'(RAM_NUM);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_READ, ST_DRAIN, ST_REL, ST_FLUSH} state_t;

    state_t                        state_reg;
    logic [KERNEL_BITWIDTH-1:0]    kernel_reg;
    logic [RAM_ADDR_BITWIDTH-1:0]  width_reg;
    logic [HEIGHT_BITWIDTH-1:0]    height_reg;
    logic [HEIGHT_BITWIDTH-1:0]    out_line_reg;
    logic [NB-1:0]                 lines_avail_reg;
    logic [NB-1:0]                 rd_base_reg;
    logic                          write_done_d_reg;
    logic [RAM_ADDR_BITWIDTH-1:0]  addr_reg;
    logic [RAM_NUM-1:0]            enb_reg;
    logic [SW-1:0]                 step_reg;
    logic [RAM_RD_LATENCY-1:0]     valid_pipe_reg;
    logic [RAM_RD_LATENCY-1:0]     last_pipe_reg;
    logic                          read_done_reg;
    logic [NB-1:0]                 read_num_reg;
    logic                          frame_done_reg;

    logic                          cfg_ok;
    logic                          wd_rise;
    logic                          issue;
    logic                          issue_last;
    logic                          rel_fire;
    logic [NB-1:0]                 rel_num;
    logic [IW-1:0]                 base_w;
    logic [IW-1:0]                 base_sum;
    logic [NB-1:0]                 base_next;
    logic [AW-1:0]                 avail_sum;
    logic [AW-1:0]                 avail_next;
    logic [RAM_NUM-1:0]            active_mask;

    assign cfg_ok = (cfg_kernel_size != '0)
                 && (cfg_kernel_size <= KERNEL_BITWIDTH'(KERNEL_MAX))
                 && (cfg_img_width != '0)
                 && (cfg_img_width <= RAM_ADDR_BITWIDTH'(RAM_DEEP))
                 && (cfg_img_height >= HEIGHT_BITWIDTH'(cfg_kernel_size));

    assign wd_rise    = ram_write_done & ~write_done_d_reg;
    assign issue      = |enb_reg;
    assign issue_last = issue && (addr_reg == width_reg - 1'b1);
    assign base_w     = IW'(rd_base_reg);

    // Line releases: one per output line, then the K-1 lines still held at frame end.
    always_comb begin
        rel_fire = 1'b0;
        rel_num  = '0;
        if (state_reg == ST_REL) begin
            rel_fire = 1'b1;
            rel_num  = NB'(1);
        end else if (state_reg == ST_FLUSH && step_reg == SW'(2)
                     && kernel_reg > KERNEL_BITWIDTH'(1)) begin
            rel_fire = 1'b1;
            rel_num  = NB'(kernel_reg - KERNEL_BITWIDTH'(1));
        end
        base_sum  = base_w + IW'(rel_num);
        base_next = (base_sum >= RAM_NUM_I) ? NB'(base_sum - RAM_NUM_I) : NB'(base_sum);
    end

    always_comb begin
        avail_sum = AW'(lines_avail_reg) + (wd_rise ? AW'(ram_write_num) : '0);
        if (avail_sum <= AW'(rel_num)) begin
            avail_next = '0;
        end else begin
            avail_next = avail_sum - AW'(rel_num);
        end
        if (avail_next > AW'(RAM_NUM)) begin
            avail_next = AW'(RAM_NUM);
        end
    end

    // A RAM is active when its distance from rd_base around the ring is below K.
    genvar gi;
    generate
        for (gi = 0; gi < RAM_NUM; gi++) begin : g_mask
            localparam logic [IW-1:0] J = IW'(gi);
            logic [IW-1:0] offset_w;
            assign offset_w        = (J >= base_w) ? J - base_w : J + RAM_NUM_I - base_w;
            assign active_mask[gi] = offset_w < IW'(kernel_reg);
        end

        for (gi = 0; gi < KERNEL_MAX; gi++) begin : g_row
            logic [IW-1:0] sum_w;
            logic [IW-1:0] idx_w;
            assign sum_w = base_w + IW'(gi);
            assign idx_w = (sum_w >= RAM_NUM_I) ? sum_w - RAM_NUM_I : sum_w;
            assign m_axis_matrix_data[gi*D +: D] =
                (m_axis_matrix_valid && (KERNEL_BITWIDTH'(gi) < kernel_reg))
                ? ram_doutb[int'(idx_w)*D +: D] : '0;
        end
    endgenerate

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_reg        <= ST_IDLE;
            kernel_reg       <= '0;
            width_reg        <= '0;
            height_reg       <= '0;
            out_line_reg     <= '0;
            lines_avail_reg  <= '0;
            rd_base_reg      <= '0;
            write_done_d_reg <= 1'b0;
            addr_reg         <= '0;
            enb_reg          <= '0;
            step_reg         <= '0;
            valid_pipe_reg   <= '0;
            last_pipe_reg    <= '0;
            read_done_reg    <= 1'b0;
            read_num_reg     <= '0;
            frame_done_reg   <= 1'b0;
        end else begin
            write_done_d_reg <= ram_write_done;
            lines_avail_reg  <= (state_reg == ST_IDLE) ? '0 : NB'(avail_next);
            read_done_reg    <= rel_fire;
            read_num_reg     <= rel_fire ? rel_num : '0;
            if (rel_fire) begin
                rd_base_reg <= base_next;
            end
            valid_pipe_reg <= (valid_pipe_reg << 1) | RAM_RD_LATENCY'(issue);
            last_pipe_reg  <= (last_pipe_reg << 1) | RAM_RD_LATENCY'(issue_last);
            frame_done_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (s_start && cfg_ok) begin
                        kernel_reg   <= cfg_kernel_size;
                        width_reg    <= cfg_img_width;
                        height_reg   <= cfg_img_height;
                        out_line_reg <= '0;
                        state_reg    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (AW'(lines_avail_reg) >= AW'(kernel_reg)) begin
                        enb_reg   <= active_mask;
                        addr_reg  <= '0;
                        state_reg <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (addr_reg == width_reg - 1'b1) begin
                        enb_reg   <= '0;
                        addr_reg  <= '0;
                        step_reg  <= '0;
                        state_reg <= ST_DRAIN;
                    end else begin
                        addr_reg <= addr_reg + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (step_reg == SW'(RAM_RD_LATENCY - 1)) begin
                        state_reg <= ST_REL;
                    end else begin
                        step_reg <= step_reg + 1'b1;
                    end
                end
                ST_REL: begin
                    out_line_reg <= out_line_reg + 1'b1;
                    step_reg     <= '0;
                    if (out_line_reg == height_reg - HEIGHT_BITWIDTH'(kernel_reg)) begin
                        state_reg <= ST_FLUSH;
                    end else begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_FLUSH: begin
                    // Two idle cycles before the flush release keep release pulses edge-detectable.
                    step_reg <= step_reg + 1'b1;
                    if (step_reg == SW'(3)) begin
                        frame_done_reg <= 1'b1;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ram_enb             = enb_reg;
    assign ram_addrb           = addr_reg;
    assign ram_read_done       = read_done_reg;
    assign ram_read_num        = read_num_reg;
    assign m_axis_matrix_valid = valid_pipe_reg[RAM_RD_LATENCY-1];
    assign m_axis_matrix_last  = last_pipe_reg[RAM_RD_LATENCY-1];
    assign m_frame_done        = frame_done_reg;

endmodule

// File: tb/tb_scaler_matrix_read.sv
// Scoreboard bench for scaler_matrix_read: a writer model fills the RAM ring and
// queues the expected matrix columns and line releases; a monitor checks them.
module tb_scaler_matrix_read;
    localparam int KMAX = 4;
    localparam int RN   = 5;
    localparam int NB   = 3;
    localparam int KB   = 3;
    localparam int AB   = 12;
    localparam int DW   = 8;
    localparam int HB   = 12;
    localparam int DEEP = 3840;

    logic              s_clk;
    logic              s_rst_n;
    logic              s_start;
    logic [KB-1:0]     cfg_kernel_size;
    logic [AB-1:0]     cfg_img_width;
    logic [HB-1:0]     cfg_img_height;
    logic              ram_write_done;
    logic [NB-1:0]     ram_write_num;
    logic [RN-1:0]     ram_enb;
    logic [AB-1:0]     ram_addrb;
    logic [RN*DW-1:0]  ram_doutb;
    logic              ram_read_done;
    logic [NB-1:0]     ram_read_num;
    logic              m_valid;
    logic [KMAX*DW-1:0] m_data;
    logic              m_last;
    logic              m_frame_done;

    scaler_matrix_read dut (
        .s_clk               (s_clk),
        .s_rst_n             (s_rst_n),
        .s_start             (s_start),
        .cfg_kernel_size     (cfg_kernel_size),
        .cfg_img_width       (cfg_img_width),
        .cfg_img_height      (cfg_img_height),
        .ram_write_done      (ram_write_done),
        .ram_write_num       (ram_write_num),
        .ram_enb             (ram_enb),
        .ram_addrb           (ram_addrb),
        .ram_doutb           (ram_doutb),
        .ram_read_done       (ram_read_done),
        .ram_read_num        (ram_read_num),
        .m_axis_matrix_valid (m_valid),
        .m_axis_matrix_data  (m_data),
        .m_axis_matrix_last  (m_last),
        .m_frame_done        (m_frame_done)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    // Line RAM ring with a two-cycle read latency.
    logic [DW-1:0] ram_mem [RN][DEEP];
    logic [DW-1:0] rd1 [RN];
    logic [DW-1:0] rd2 [RN];

    always @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int j = 0; j < RN; j++) begin
                rd1[j] <= '0;
                rd2[j] <= '0;
            end
        end else begin
            for (int j = 0; j < RN; j++) begin
                if (ram_enb[j]) rd1[j] <= ram_mem[j][ram_addrb];
                rd2[j] <= rd1[j];
            end
        end
    end

    always_comb begin
        ram_doutb = '0;
        for (int j = 0; j < RN; j++) ram_doutb[j*DW +: DW] = rd2[j];
    end

    typedef struct packed {
        logic [KMAX*DW-1:0] data;
        logic [AB-1:0]      addr;
        logic [RN-1:0]      enb;
        logic               last;
    } beat_t;

    beat_t         exp_q[$];
    int            rel_q[$];
    logic [DW-1:0] pix [16][32];
    int  total = 0;
    int  bad = 0;
    int  written = 0;
    int  released = 0;
    int  wr_slot = 0;
    int  frame_base = 0;
    int  frames_done = 0;
    int  beats_seen = 0;
    int  cyc = 0;
    int  last_rel_cyc = -100;
    bit  abort_w = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every DUT output event against the queued expectations.
    initial begin
        logic [RN-1:0] enb_h1;
        logic [RN-1:0] enb_h2;
        logic [AB-1:0] addr_h1;
        logic [AB-1:0] addr_h2;
        logic          prev_valid;
        beat_t         b;
        enb_h1 = '0; enb_h2 = '0; addr_h1 = '0; addr_h2 = '0; prev_valid = 1'b0;
        forever begin
            @(negedge s_clk);
            cyc++;
            if (!s_rst_n) begin
                enb_h1 = '0; enb_h2 = '0; addr_h1 = '0; addr_h2 = '0; prev_valid = 1'b0;
            end else begin
                if (m_valid) begin
                    beats_seen++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_beat: got data %0h with no beat expected", m_data);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_data", 64'(m_data), 64'(b.data));
                        chk("beat_last", 64'(m_last), 64'(b.last));
                        chk("beat_enb_2cyc_before", 64'(enb_h2), 64'(b.enb));
                        chk("beat_addr_2cyc_before", 64'(addr_h2), 64'(b.addr));
                        if (b.addr != 0) chk("beat_contiguous", 64'(prev_valid), 64'd1);
                        $display("beat x=%0d data=%h last=%b enb=%b", b.addr, m_data, m_last, enb_h2);
                    end
                end
                if (ram_read_done) begin
                    released += int'(ram_read_num);
                    total++;
                    if (cyc - last_rel_cyc < 2) begin
                        bad++;
                        $display("FAIL release_gap: got %0d cycles required >=2", cyc - last_rel_cyc);
                    end
                    last_rel_cyc = cyc;
                    total++;
                    if (rel_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_release: got num %0d with none expected", ram_read_num);
                    end else begin
                        total--;
                        chk("release_num", 64'(ram_read_num), 64'(rel_q.pop_front()));
                    end
                    $display("release num=%0d", ram_read_num);
                end
                if (m_frame_done) begin
                    frames_done++;
                    chk("frame_done_beats_left", 64'(exp_q.size()), 64'd0);
                    chk("frame_done_releases_left", 64'(rel_q.size()), 64'd0);
                    $display("frame_done #%0d", frames_done);
                end
                prev_valid = m_valid;
                enb_h2  = enb_h1;
                addr_h2 = addr_h1;
                enb_h1  = ram_enb;
                addr_h1 = ram_addrb;
            end
        end
    end

    // Writer model: fills one line per done pulse, respecting ring occupancy, and
    // queues the output line that the newly written line completes.
    task automatic writer(input int k, input int w, input int h, input int pw,
                          input int stall_line, input int stall_cyc);
        beat_t b;
        for (int l = 0; l < h; l++) begin
            while ((written - released >= RN) && !abort_w) @(negedge s_clk);
            if (abort_w) break;
            if (l == stall_line) repeat (stall_cyc) @(negedge s_clk);
            repeat ($urandom_range(0, 3)) @(negedge s_clk);
            for (int x = 0; x < w; x++) begin
                pix[l][x] = DW'($urandom);
                ram_mem[wr_slot][x] = pix[l][x];
            end
            if (l >= k - 1) begin
                for (int x = 0; x < w; x++) begin
                    b = '0;
                    for (int r = 0; r < k; r++) begin
                        b.data[r*DW +: DW] = pix[l-k+1+r][x];
                        b.enb[(frame_base + l - k + 1 + r) % RN] = 1'b1;
                    end
                    b.addr = AB'(x);
                    b.last = (x == w - 1);
                    exp_q.push_back(b);
                end
            end
            ram_write_num  = NB'(1);
            ram_write_done = 1'b1;
            written++;
            repeat (pw) @(negedge s_clk);
            ram_write_done = 1'b0;
            @(negedge s_clk);
            wr_slot = (wr_slot + 1) % RN;
        end
    endtask

    task automatic start_frame(input int k, input int w, input int h);
        @(negedge s_clk);
        cfg_kernel_size = KB'(k);
        cfg_img_width   = AB'(w);
        cfg_img_height  = HB'(h);
        s_start = 1'b1;
        @(negedge s_clk);
        s_start = 1'b0;
    endtask

    task automatic run_frame(input int k, input int w, input int h, input int pw,
                             input int stall_line, input int stall_cyc);
        int fd0;
        int t;
        fd0 = frames_done;
        frame_base = wr_slot;
        for (int i = 0; i <= h - k; i++) rel_q.push_back(1);
        if (k > 1) rel_q.push_back(k - 1);
        $display("frame start K=%0d W=%0d H=%0d base=%0d", k, w, h, frame_base);
        start_frame(k, w, h);
        abort_w = 1'b0;
        t = 0;
        fork
            writer(k, w, h, pw, stall_line, stall_cyc);
            begin
                while (frames_done == fd0 && t < 20000) begin
                    @(negedge s_clk);
                    t++;
                end
                if (frames_done == fd0) abort_w = 1'b1;
            end
        join
        repeat (6) @(negedge s_clk);
        chk("frame_done_count", 64'(frames_done - fd0), 64'd1);
        exp_q.delete();
        rel_q.delete();
    endtask

    task automatic cfg_error(input int k, input int w, input int h);
        int bs;
        int rs;
        bs = beats_seen;
        rs = released;
        start_frame(k, w, h);
        repeat (30) @(negedge s_clk);
        chk("cfg_error_no_beats", 64'(beats_seen - bs), 64'd0);
        chk("cfg_error_no_release", 64'(released - rs), 64'd0);
        $display("cfg error K=%0d W=%0d H=%0d ignored", k, w, h);
    endtask

    task automatic reset_mid_line();
        int bs;
        int t;
        frame_base = wr_slot;
        for (int i = 0; i < 3; i++) rel_q.push_back(1);
        rel_q.push_back(2);
        start_frame(3, 8, 5);
        abort_w = 1'b0;
        bs = beats_seen;
        t = 0;
        fork
            writer(3, 8, 5, 2, -1, 0);
            begin
                while (beats_seen < bs + 3 && t < 5000) begin
                    @(negedge s_clk);
                    t++;
                end
                chk("reset_reached_mid_line", 64'(beats_seen >= bs + 3), 64'd1);
                #2;
                s_rst_n = 1'b0;
                #1;
                chk("rst_valid", 64'(m_valid), 64'd0);
                chk("rst_data", 64'(m_data), 64'd0);
                chk("rst_last", 64'(m_last), 64'd0);
                chk("rst_enb", 64'(ram_enb), 64'd0);
                chk("rst_addr", 64'(ram_addrb), 64'd0);
                chk("rst_read_done", 64'(ram_read_done), 64'd0);
                chk("rst_frame_done", 64'(m_frame_done), 64'd0);
                abort_w = 1'b1;
            end
        join
        $display("reset asserted mid-line");
        exp_q.delete();
        rel_q.delete();
        written = 0;
        released = 0;
        wr_slot = 0;
        ram_write_done = 1'b0;
        repeat (3) @(negedge s_clk);
        s_rst_n = 1'b1;
        repeat (2) @(negedge s_clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int w;
        int h;
        s_rst_n = 1'b0;
        s_start = 1'b0;
        cfg_kernel_size = '0;
        cfg_img_width = '0;
        cfg_img_height = '0;
        ram_write_done = 1'b0;
        ram_write_num = '0;
        repeat (3) @(negedge s_clk);
        chk("reset_valid", 64'(m_valid), 64'd0);
        chk("reset_enb", 64'(ram_enb), 64'd0);
        chk("reset_read_done", 64'(ram_read_done), 64'd0);
        chk("reset_frame_done", 64'(m_frame_done), 64'd0);
        chk("reset_data", 64'(m_data), 64'd0);
        s_rst_n = 1'b1;
        repeat (2) @(negedge s_clk);

        run_frame(3, 8, 5, 6, -1, 0);
        run_frame(3, 6, 4, 2, 2, 50);
        run_frame(4, 5, 12, 2, -1, 0);
        run_frame(1, 1, 1, 1, -1, 0);
        cfg_error(0, 4, 3);
        cfg_error(5, 4, 6);
        cfg_error(2, 0, 3);
        cfg_error(3, 4, 2);
        run_frame(2, 3, 3, 1, -1, 0);
        for (int i = 0; i < 4; i++) begin
            k = $urandom_range(1, 4);
            w = $urandom_range(1, 20);
            h = $urandom_range(k, k + 6);
            run_frame(k, w, h, $urandom_range(1, 4), -1, 0);
        end
        reset_mid_line();
        run_frame(2, 5, 4, 3, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
